// File: rtl/miner_header_loader_if.sv
// Header word stream in, job fields out: the loader is the slave side of this bundle.
interface miner_header_loader_if #(
    parameter int unsigned JOB_ID_W = 4
);
    logic                s_valid;
    logic                s_ready;
    logic [31:0]         s_data;
    logic                s_last;
    logic                job_valid_o;
    logic                job_ready;
    logic [511:0]        block1_fixed_o;
    logic [95:0]         tail_fixed_o;
    logic [31:0]         nonce_start_o;
    logic [JOB_ID_W-1:0] job_id_o;
    logic                err_len_o;

    modport master (
        output s_valid, s_data, s_last, job_ready,
        input  s_ready, job_valid_o, block1_fixed_o, tail_fixed_o,
               nonce_start_o, job_id_o, err_len_o
    );

    modport slave (
        input  s_valid, s_data, s_last, job_ready,
        output s_ready, job_valid_o, block1_fixed_o, tail_fixed_o,
               nonce_start_o, job_id_o, err_len_o
    );
endinterface

// File: rtl/miner_header_loader.sv
// Collects a 20-word block header into shadow registers and presents it as one
// job (block1, tail, starting nonce, id) on a valid/ready output.
module miner_header_loader #(
    parameter bit          BYTE_SWAP = 1'b0,
    parameter int unsigned JOB_ID_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    miner_header_loader_if.slave    bus
);
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned LAST_IDX  = 19;
    localparam int unsigned TAIL_BASE = 16;

    typedef enum logic {FILL, PEND} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                s_ready_q;
    logic                err_q, err_d;
    logic                store_d, commit_d, commit_w_d, nonce_latch_d;
    logic                accept, slot_free;
    logic [31:0]         w;

    logic [511:0]        block1_sh, block1_q;
    logic [95:0]         tail_sh, tail_q;
    logic [31:0]         nonce_sh, nonce_q;
    logic                job_valid_q;
    logic [JOB_ID_W-1:0] job_id_q;

    assign bus.s_ready        = s_ready_q;
    assign bus.err_len_o      = err_q;
    assign bus.job_valid_o    = job_valid_q;
    assign bus.job_id_o       = job_id_q;
    assign bus.block1_fixed_o = block1_q;
    assign bus.tail_fixed_o   = tail_q;
    assign bus.nonce_start_o  = nonce_q;

    assign accept    = bus.s_valid && s_ready_q;
    assign slot_free = !job_valid_q || bus.job_ready;

    // Host words arrive little-endian when BYTE_SWAP is set; SHA wants big-endian.
    always_comb begin
        if (BYTE_SWAP)
            w = {bus.s_data[7:0], bus.s_data[15:8], bus.s_data[23:16], bus.s_data[31:24]};
        else
            w = bus.s_data;
    end

    // Next-state, frame length checking and commit decision.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_d         = 1'b0;
        store_d       = 1'b0;
        commit_d      = 1'b0;
        commit_w_d    = 1'b0;
        nonce_latch_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (idx_q != IDX_W'(LAST_IDX)) begin
                        if (bus.s_last) begin
                            idx_d = '0;
                            err_d = 1'b1;
                        end else begin
                            store_d = 1'b1;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d = '0;
                        if (!bus.s_last) begin
                            err_d = 1'b1;
                        end else if (slot_free) begin
                            commit_d   = 1'b1;
                            commit_w_d = 1'b1;
                        end else begin
                            nonce_latch_d = 1'b1;
                            state_d       = PEND;
                        end
                    end
                end
            end
            PEND: begin
                if (bus.job_ready) begin
                    commit_d = 1'b1;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            s_ready_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_ready_q <= (state_d == FILL);
            err_q     <= err_d;
        end
    end

    // Shadow capture; word i of block1 sits at [511-32i -: 32], tail words at [95-32(i-16) -: 32].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block1_sh <= '0;
            tail_sh   <= '0;
            nonce_sh  <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (store_d && idx_q == IDX_W'(i))
                    block1_sh[511-32*i -: 32] <= w;
            end
            for (int i = 0; i < 3; i++) begin
                if (store_d && idx_q == IDX_W'(TAIL_BASE + i))
                    tail_sh[95-32*i -: 32] <= w;
            end
            if (nonce_latch_d)
                nonce_sh <= w;
        end
    end

    // Output job registers; a consume without commit frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block1_q    <= '0;
            tail_q      <= '0;
            nonce_q     <= '0;
            job_valid_q <= 1'b0;
            job_id_q    <= '0;
        end else if (commit_d) begin
            block1_q    <= block1_sh;
            tail_q      <= tail_sh;
            nonce_q     <= commit_w_d ? w : nonce_sh;
            job_valid_q <= 1'b1;
            job_id_q    <= job_id_q + JOB_ID_W'(1);
        end else if (bus.job_ready) begin
            job_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/miner_header_loader.md
Name: miner_header_loader

Overview:
- Receives an 80-byte Bitcoin block header as a stream of 20 32-bit words on a valid/ready interface.
- Splits it into the job fields consumed by miner_blockgen: block1_fixed (words 0-15), tail_fixed (words 16-18) and the starting nonce (word 19).
- Presents each completed header as one job on a valid/ready output with an incrementing job ID.
- Sits between the host/UART command path and the nonce-sweep controller.

Parameters:
- BYTE_SWAP, 0: 1 = byte-reverse every input word on capture (little-endian host order to SHA big-endian); 0 = capture as-is.
- JOB_ID_W, 4: width of the job ID counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- s_valid  input  1  input word valid
- s_ready  output  1  loader can accept a word
- s_data  input  32  header word
- s_last  input  1  marks the final word of a header frame
- job_valid_o  output  1  job outputs hold a valid, unconsumed job
- job_ready  input  1  consumer accepts the job
- block1_fixed_o  output  512  header words 0-15; word i occupies bits [511-32i -: 32]
- tail_fixed_o  output  96  words 16,17,18 in bits [95:64], [63:32], [31:0]
- nonce_start_o  output  32  word 19
- job_id_o  output  JOB_ID_W  ID of the presented job
- err_len_o  output  1  one-cycle pulse: malformed frame discarded

Behaviour:
- Word transfer occurs when s_valid && s_ready at a rising clk edge. Word index idx (5 bits, 0..19) counts accepted words in the current frame.
- Each captured word is w = BYTE_SWAP ? {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]} : s_data.
- Accepted words with idx 0..18 are written into the shadow registers (block1 shadow or tail shadow) at the positions listed under Ports.

State machine (states FILL, PEND):
- FILL:
  - s_ready = 1.
  - Accepted word, idx < 19, s_last = 0: store the word; idx++.
  - Accepted word, idx < 19, s_last = 1: early end. Discard the frame, idx <= 0, err_len_o pulses the next cycle.
  - Accepted word, idx = 19, s_last = 0: overlength. Discard, idx <= 0, err_len_o pulses the next cycle.
  - Accepted word, idx = 19, s_last = 1: good frame; idx <= 0.
    - If the output slot is free (!job_valid_o || job_ready): commit this edge and stay in FILL.
    - Otherwise latch the word into the nonce shadow and go to PEND.
- PEND:
  - s_ready = 0.
  - When job_ready is asserted: commit from the shadow at that edge and return to FILL.

Commit (a single clock edge):
- Output registers load from the shadow registers.
- nonce_start_o loads w directly when the commit happens in FILL, or the nonce shadow when it happens in PEND.
- job_valid_o <= 1.
- job_id_o <= job_id_o + 1. The counter wraps modulo 2^JOB_ID_W; the first job after reset has ID 1.

Output handshake:
- job_valid_o stays high and all job outputs stay stable until job_ready is asserted.
- A consume with no commit on the same edge clears job_valid_o. A consume and a commit on the same edge keep job_valid_o at 1 with the new contents.
- job_ready while job_valid_o = 0 is ignored.

Latency and throughput:
- Last word accepted at edge N with a free slot: job_valid_o = 1 and fields valid after edge N (0 extra cycles).
- Back-to-back frames are supported at one word per cycle while the consumer keeps up.

Reset:
- Asynchronous; clears everything at any time, including mid-frame and in PEND.
- Values after reset: idx = 0, state FILL, s_ready = 1, job_valid_o = 0, job_id_o = 0, err_len_o = 0, and all field outputs and shadows = 0.
- A partially received frame is lost.

Other rules:
- err_len_o never asserts with a commit in the same cycle.
- An error frame does not disturb the currently presented job.

Test Plan:
- BYTE_SWAP = 0, words 0x00000000+i for i = 0..19 with s_last on word 19, job_ready = 0 → one cycle later: job_valid_o = 1, job_id_o = 1, block1_fixed_o[511:480] = 0x00000000, block1_fixed_o[31:0] = 0x0000000F, tail_fixed_o = {0x10, 0x11, 0x12} (one word each), nonce_start_o = 0x00000013.
- BYTE_SWAP = 1, word 0 = 0x01020304 → block1_fixed_o[511:480] = 0x04030201. Word 19 = 0xAABBCCDD → nonce_start_o = 0xDDCCBBAA.
- s_last on the 7th word (idx 6) → err_len_o pulses exactly one cycle, job_valid_o stays 0. The next good 20-word frame commits normally with job_id_o = 1.
- Job 1 held (job_ready = 0) and second frame completes → s_ready = 0 (PEND). Raise job_ready for one cycle → job_id_o = 2 with frame-2 fields, job_valid_o stays 1, s_ready returns to 1.
- Assert rst after word 10 of a frame → all outputs 0, s_ready = 1. A fresh 20-word frame then yields job_id_o = 1.
- JOB_ID_W = 2, 5 frames each consumed immediately → job_id_o sequence 1, 2, 3, 0, 1.
